// File: rtl/phy_rx_nibble_deframer.sv
// Receive-side nibble deframer: rebuilds bytes from the 4-bit PHY stream and
// reports each finished frame as a {count, count} control block plus an error flag.
module phy_rx_nibble_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 2047
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic        phy_rx_dv,
  input  logic [3:0]  phy_rx_data,
  output logic [7:0]  f_data_out,
  output logic        f_data_valid,
  output logic [23:0] f_ctrl_out,
  output logic        f_frame_valid,
  output logic        f_frame_err,
  output logic [2:0]  state_dbg
);

  // Handshake: no backpressure. f_data_valid and f_frame_valid are single-cycle
  // strobes; their payloads are only meaningful while the strobe is high.

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    IDLE = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [11:0] MIN_C   = 12'(MIN_LEN);
  localparam logic [11:0] MAX_C   = 12'(MAX_LEN);
  localparam logic [11:0] CNT_SAT = 12'hFFF;

  state_t      state;
  state_t      next_state;
  logic [3:0]  low_nib;
  logic [11:0] byte_cnt;
  logic        cap_lo;
  logic        clr_cnt;
  logic        emit_byte;
  logic        end_frame;
  logic        odd_end;
  logic        len_bad;

  assign state_dbg = state;
  assign len_bad   = (byte_cnt < MIN_C) || (byte_cnt > MAX_C);

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cap_lo     = 1'b0;
    clr_cnt    = 1'b0;
    emit_byte  = 1'b0;
    end_frame  = 1'b0;
    odd_end    = 1'b0;
    case (state)
      // A reset released mid-frame must not deliver the tail of that frame.
      SYNC: if (!phy_rx_dv) next_state = IDLE;
      IDLE: begin
        if (phy_rx_dv) begin
          cap_lo     = 1'b1;
          clr_cnt    = 1'b1;
          next_state = HI;
        end
      end
      LO: begin
        if (phy_rx_dv) begin
          cap_lo     = 1'b1;
          next_state = HI;
        end else begin
          end_frame  = 1'b1;
          next_state = DONE;
        end
      end
      HI: begin
        if (phy_rx_dv) begin
          emit_byte  = 1'b1;
          next_state = LO;
        end else begin
          end_frame  = 1'b1;
          odd_end    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (phy_rx_dv) begin
          cap_lo     = 1'b1;
          clr_cnt    = 1'b1;
          next_state = HI;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = SYNC;
    endcase
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      low_nib  <= 4'h0;
      byte_cnt <= 12'h000;
    end else begin
      if (cap_lo) low_nib <= phy_rx_data;
      if (clr_cnt) byte_cnt <= 12'h000;
      else if (emit_byte && byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 12'd1;
    end
  end

  // The strobe is set on the edge that samples the high nibble, so a finished frame
  // (set on the edge that samples dv low) always trails the last byte by one cycle.
  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      f_data_out    <= 8'h00;
      f_data_valid  <= 1'b0;
      f_ctrl_out    <= 24'h000000;
      f_frame_valid <= 1'b0;
      f_frame_err   <= 1'b0;
    end else begin
      f_data_valid  <= emit_byte;
      if (emit_byte) f_data_out <= {phy_rx_data, low_nib};
      f_frame_valid <= end_frame;
      f_ctrl_out    <= end_frame ? {byte_cnt, byte_cnt} : 24'h000000;
      f_frame_err   <= end_frame & (odd_end | len_bad);
    end
  end

endmodule

// File: tb/tb_phy_rx_nibble_deframer.sv
// Scoreboard bench for phy_rx_nibble_deframer: the driver pushes expected bytes and
// frame reports (with their expected cycle) while a negedge monitor pops and compares.
module tb_phy_rx_nibble_deframer;

  logic        clk_phy = 1'b0;
  logic        reset = 1'b0;
  logic        phy_rx_dv = 1'b0;
  logic [3:0]  phy_rx_data = 4'h0;
  logic [7:0]  f_data_out;
  logic        f_data_valid;
  logic [23:0] f_ctrl_out;
  logic        f_frame_valid;
  logic        f_frame_err;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [3:0]  nib_q[$];
  logic [7:0]  exp_q[$];
  int          byte_cyc_q[$];
  logic [24:0] frame_exp_q[$];
  int          frame_cyc_q[$];

  phy_rx_nibble_deframer #(.MIN_LEN(64), .MAX_LEN(2047)) dut (
    .clk_phy(clk_phy),
    .reset(reset),
    .phy_rx_dv(phy_rx_dv),
    .phy_rx_data(phy_rx_data),
    .f_data_out(f_data_out),
    .f_data_valid(f_data_valid),
    .f_ctrl_out(f_ctrl_out),
    .f_frame_valid(f_frame_valid),
    .f_frame_err(f_frame_err),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk_phy = ~clk_phy;
  always @(posedge clk_phy) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // reference model: a frame of n nibbles yields n/2 bytes; count saturates at 4095
  function automatic logic [24:0] frame_model(input int n);
    int cnt;
    logic err;
    logic [11:0] c12;
    cnt = n / 2;
    if (cnt > 4095) cnt = 4095;
    err = (n % 2 == 1) || (cnt < 64) || (cnt > 2047);
    c12 = 12'(cnt);
    return {err, c12, c12};
  endfunction

  task automatic fill_random(input int n);
    nib_q.delete();
    for (int i = 0; i < n; i++) nib_q.push_back(4'($urandom_range(0, 15)));
  endtask

  task automatic fill_test1();
    nib_q.delete();
    for (int i = 0; i < 1024; i++)
      nib_q.push_back((i / 2 >= 4 && i / 2 < 508) ? 4'hF : 4'h0);
  endtask

  // driver: sends nib_q as one frame, then holds dv low for gap cycles
  task automatic send_frame(input int gap);
    int n;
    n = nib_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk_phy);
      phy_rx_dv   = 1'b1;
      phy_rx_data = nib_q[i];
      if (i % 2 == 1) begin
        exp_q.push_back({nib_q[i], nib_q[i-1]});
        byte_cyc_q.push_back(cyc + 1);
      end
    end
    @(negedge clk_phy);
    phy_rx_dv   = 1'b0;
    phy_rx_data = 4'($urandom_range(0, 15));
    frame_exp_q.push_back(frame_model(n));
    frame_cyc_q.push_back(cyc + 1);
    for (int g = 1; g < gap; g++) begin
      @(negedge clk_phy);
      phy_rx_data = 4'($urandom_range(0, 15));
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk_phy) begin
    if (f_data_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte at cycle %0d: got %0h, expected no strobe", cyc, f_data_out);
      end else begin
        check("byte_value", 32'(f_data_out), 32'(exp_q.pop_front()));
        check("byte_cycle", 32'(cyc), 32'(byte_cyc_q.pop_front()));
      end
    end
    if (f_frame_valid) begin
      if (frame_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame at cycle %0d: got %0h, expected no strobe", cyc, f_ctrl_out);
      end else begin
        check("frame_report", 32'({f_frame_err, f_ctrl_out}), 32'(frame_exp_q.pop_front()));
        check("frame_cycle", 32'(cyc), 32'(frame_cyc_q.pop_front()));
      end
    end else begin
      check("idle_ctrl_err", 32'({f_frame_err, f_ctrl_out}), 32'h0);
    end
  end

  task automatic check_all_zero(input string name);
    check(name, 32'({f_data_out, f_data_valid, f_frame_valid, f_frame_err}), 32'h0);
    check({name, "_ctrl"}, 32'(f_ctrl_out), 32'h0);
  endtask

  initial begin
    int t;
    // reset block
    repeat (3) @(negedge clk_phy);
    #1 check_all_zero("reset_outputs");
    @(negedge clk_phy);
    reset = 1'b1;
    repeat (2) @(negedge clk_phy);

    // 512-byte patterned frame
    fill_test1();
    send_frame(2);

    // back-to-back 512-byte frames with a single dv-low cycle between them
    for (int f = 0; f < 16; f++) begin
      fill_random(1024);
      send_frame(1);
    end

    // 129 nibbles: odd end after 64 bytes
    fill_random(129);
    send_frame(2);

    // short, single-nibble and overlong frames
    fill_random(20);
    send_frame(1);
    fill_random(1);
    send_frame(2);
    fill_random(4096);
    send_frame(3);

    // min/max boundaries and random lengths
    fill_random(126); send_frame(1);
    fill_random(128); send_frame(2);
    fill_random(4094); send_frame(1);
    for (int f = 0; f < 8; f++) begin
      fill_random($urandom_range(1, 400));
      send_frame($urandom_range(1, 3));
    end

    // reset pulse inside a frame: nothing more from that frame, next frame clean
    fill_random(400);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_phy);
      phy_rx_dv   = 1'b1;
      phy_rx_data = nib_q[i];
      if (i % 2 == 1) begin
        exp_q.push_back({nib_q[i], nib_q[i-1]});
        byte_cyc_q.push_back(cyc + 1);
      end
    end
    @(negedge clk_phy);
    phy_rx_data = nib_q[200];
    @(negedge clk_phy);
    reset = 1'b0;
    phy_rx_data = nib_q[201];
    #1 check_all_zero("mid_frame_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_phy);
      phy_rx_data = 4'($urandom_range(0, 15));
    end
    #1 check_all_zero("mid_frame_reset_hold");
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_phy);
      phy_rx_data = 4'($urandom_range(0, 15));
    end
    @(negedge clk_phy);
    phy_rx_dv = 1'b0;
    @(negedge clk_phy);
    fill_random(128);
    send_frame(2);

    // 3,A byte ordering and saturated count
    fill_random(128);
    nib_q[0] = 4'h3;
    nib_q[1] = 4'hA;
    send_frame(2);
    fill_random(8192);
    send_frame(2);

    // drain with a bounded wait
    t = 0;
    while ((exp_q.size() != 0 || frame_exp_q.size() != 0) && t < 200) begin
      @(negedge clk_phy);
      t++;
    end
    check("pending_bytes", 32'(exp_q.size()), 32'h0);
    check("pending_frames", 32'(frame_exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
